vga_timing_gen: RTL and testbench

Parametrised raster timing generator, the successor to the fixed 640x480 sync block. It derives a pixel-rate enable from the system clock and runs horizontal and vertical position counters over a configurable raster. It produces polarity-configurable syncs, a blanking/active qualifier and line/frame start strobes, all mutually aligned. It sits between the clock domain root and every pixel source (framebuffer reader, text/sprite renderers).

---
 rtl/vga_timing_pkg.sv | 41 ++++
 rtl/vga_timing_gen_if.sv | 36 +++
 rtl/vga_axis_counter.sv | 66 ++++++
 rtl/vga_timing_gen.sv | 121 ++++++++++++
 tb/tb_vga_timing_gen.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Raster constants, axis parameter set and sync-window helper shared by the VGA timing generator.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } axis_cfg_t;

  typedef struct packed {
    int unsigned first;
    int unsigned last;
  } sync_win_t;

  // 640x480@60
  localparam axis_cfg_t H_640 = '{active: 640, front: 16, sync: 96, back: 48};
  localparam axis_cfg_t V_480 = '{active: 480, front: 10, sync: 2, back: 33};

  // 800x600@60
  localparam axis_cfg_t H_800 = '{active: 800, front: 40, sync: 128, back: 88};
  localparam axis_cfg_t V_600 = '{active: 600, front: 1, sync: 4, back: 23};

  function automatic int unsigned axis_total(input axis_cfg_t cfg);
    return cfg.active + cfg.front + cfg.sync + cfg.back;
  endfunction

  // Inclusive sync interval; empty (last < first) when sync is zero.
  function automatic sync_win_t sync_window(input axis_cfg_t cfg);
    sync_win_t win;
    win.first = cfg.active + cfg.front;
    win.last  = cfg.active + cfg.front + cfg.sync - 1;
    return win;
  endfunction

  localparam int unsigned H_TOTAL_640 = axis_total(H_640);
  localparam int unsigned V_TOTAL_480 = axis_total(V_480);
  localparam int unsigned H_TOTAL_800 = axis_total(H_800);
  localparam int unsigned V_TOTAL_600 = axis_total(V_600);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-timing bundle between the timing generator (master) and pixel sources (slave).
// frame_cnt exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
  parameter int unsigned CW = 10
);
  logic          en;
  logic          p_tick;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          video_on;
  logic          hsync;
  logic          vsync;
  logic          vblank;
  logic          line_start;
  logic          frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  modport master (
    input  en,
    output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, vblank, line_start, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output en,
    input  p_tick, pixel_x, pixel_y, video_on, hsync, vsync, vblank, line_start, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync and active decode.
// Sync/active are computed from the next position so they stay aligned with o_pos.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FRONT  = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BACK   = 48,
  parameter bit          POL    = 1'b0,
  parameter int unsigned CW     = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_step,
  output logic [CW-1:0] o_pos,
  output logic          o_wrap,
  output logic          o_sync,
  output logic          o_active
);

  localparam axis_cfg_t CFG = '{active: ACTIVE, front: FRONT, sync: SYNC, back: BACK};
  localparam int unsigned TOTAL = axis_total(CFG);
  localparam sync_win_t   WIN   = sync_window(CFG);

  localparam logic [CW-1:0] POS_LAST   = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_FIRST = CW'(WIN.first);
  localparam logic [CW-1:0] SYNC_LAST  = CW'(WIN.last);
  localparam bit            SYNC_EN    = (SYNC != 0);

  logic [CW-1:0] r_pos;
  logic          r_sync;
  logic          r_active;

  logic [CW-1:0] w_pos_nxt;
  logic          w_last;
  logic          w_in_sync;

  always_comb begin
    w_last    = (r_pos == POS_LAST);
    w_pos_nxt = r_pos;
    if (i_step) begin
      w_pos_nxt = w_last ? '0 : r_pos + CW'(1);
    end
    w_in_sync = SYNC_EN && (w_pos_nxt >= SYNC_FIRST) && (w_pos_nxt <= SYNC_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pos    <= '0;
      r_sync   <= ~POL;
      r_active <= 1'b1;
    end else begin
      r_pos    <= w_pos_nxt;
      r_sync   <= w_in_sync ? POL : ~POL;
      r_active <= (w_pos_nxt < ACT_END);
    end
  end

  assign o_pos    = r_pos;
  assign o_wrap   = i_step && w_last;
  assign o_sync   = r_sync;
  assign o_active = r_active;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel-rate divider driving horizontal/vertical axes.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit completed-frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_640.active,
  parameter int unsigned H_FRONT   = H_640.front,
  parameter int unsigned H_SYNC    = H_640.sync,
  parameter int unsigned H_BACK    = H_640.back,
  parameter int unsigned V_ACTIVE  = V_480.active,
  parameter int unsigned V_FRONT   = V_480.front,
  parameter int unsigned V_SYNC    = V_480.sync,
  parameter int unsigned V_BACK    = V_480.back,
  parameter int unsigned CW        = 10,
  parameter int unsigned CLK_DIV   = 2,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic            clk,
  input  logic            reset_n,
  vga_timing_gen_if.master bus
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned POS_RANGE = 32'd1 << CW;
  localparam int unsigned DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  if (H_TOTAL > POS_RANGE || V_TOTAL > POS_RANGE) begin : g_cw_check
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if (CLK_DIV < 1) begin : g_div_check
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic [DW-1:0] r_div;
  logic          w_tick;

  logic [CW-1:0] w_x;
  logic [CW-1:0] w_y;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_h_sync;
  logic          w_v_sync;
  logic          w_h_active;
  logic          w_v_active;

  assign w_tick = bus.en && (r_div == DIV_LAST);

  // Divider freezes with en so a resumed run continues mid-pixel exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
    end else if (bus.en) begin
      r_div <= w_tick ? '0 : r_div + DW'(1);
    end
  end

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .POL    (HSYNC_POL),
    .CW     (CW)
  ) u_h_axis (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_step   (w_tick),
    .o_pos    (w_x),
    .o_wrap   (w_h_wrap),
    .o_sync   (w_h_sync),
    .o_active (w_h_active)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .POL    (VSYNC_POL),
    .CW     (CW)
  ) u_v_axis (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_step   (w_h_wrap),
    .o_pos    (w_y),
    .o_wrap   (w_v_wrap),
    .o_sync   (w_v_sync),
    .o_active (w_v_active)
  );

  assign bus.p_tick      = w_tick;
  assign bus.pixel_x     = w_x;
  assign bus.pixel_y     = w_y;
  assign bus.video_on    = w_h_active && w_v_active;
  assign bus.vblank      = ~w_v_active;
  assign bus.hsync       = w_h_sync;
  assign bus.vsync       = w_v_sync;
  assign bus.line_start  = w_tick && (w_x == '0);
  assign bus.frame_start = w_tick && (w_x == '0) && (w_y == '0);

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt <= '0;
    end else if (w_v_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign bus.frame_cnt = r_frame_cnt;
`else
  logic w_unused_v_wrap;
  assign w_unused_v_wrap = w_v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: 640-wide raster with short frame (CLK_DIV=2) and a tiny positive-sync raster.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(10)) bus_a ();
  vga_timing_gen_if #(.CW(10)) bus_b ();

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CW(10), .CLK_DIV(2), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) u_a (
    .clk     (clk),
    .reset_n (rst_a_n),
    .bus     (bus_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CW(10), .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_b (
    .clk     (clk),
    .reset_n (rst_b_n),
    .bus     (bus_b)
  );

  typedef struct {
    int   x;
    int   y;
    logic von;
    logic hs;
    logic vs;
    logic vb;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance (at negedges) to the first cycle presenting (x,y) on DUT A.
  task automatic wait_pos(input int x, input int y, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus_a.pixel_x == 10'(x) && bus_a.pixel_y == 10'(y)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("reach_%0d_%0d", x, y), {31'd0, found}, 32'd1);
  endtask

  initial begin
    int n;
    int hs_low;
    int hs_hi;
    int run;
    int max_run;
    int tick_low;

    tbl[0]  = '{x: 0,   y: 0, von: 1'b1, hs: 1'b1, vs: 1'b1, vb: 1'b0};
    tbl[1]  = '{x: 639, y: 0, von: 1'b1, hs: 1'b1, vs: 1'b1, vb: 1'b0};
    tbl[2]  = '{x: 640, y: 0, von: 1'b0, hs: 1'b1, vs: 1'b1, vb: 1'b0};
    tbl[3]  = '{x: 655, y: 0, von: 1'b0, hs: 1'b1, vs: 1'b1, vb: 1'b0};
    tbl[4]  = '{x: 656, y: 0, von: 1'b0, hs: 1'b0, vs: 1'b1, vb: 1'b0};
    tbl[5]  = '{x: 751, y: 0, von: 1'b0, hs: 1'b0, vs: 1'b1, vb: 1'b0};
    tbl[6]  = '{x: 752, y: 0, von: 1'b0, hs: 1'b1, vs: 1'b1, vb: 1'b0};
    tbl[7]  = '{x: 799, y: 0, von: 1'b0, hs: 1'b1, vs: 1'b1, vb: 1'b0};
    tbl[8]  = '{x: 0,   y: 3, von: 1'b1, hs: 1'b1, vs: 1'b1, vb: 1'b0};
    tbl[9]  = '{x: 0,   y: 4, von: 1'b0, hs: 1'b1, vs: 1'b1, vb: 1'b1};
    tbl[10] = '{x: 0,   y: 5, von: 1'b0, hs: 1'b1, vs: 1'b0, vb: 1'b1};
    tbl[11] = '{x: 700, y: 5, von: 1'b0, hs: 1'b0, vs: 1'b0, vb: 1'b1};
    tbl[12] = '{x: 0,   y: 6, von: 1'b0, hs: 1'b1, vs: 1'b1, vb: 1'b1};

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    bus_a.en = 1'b1;
    bus_b.en = 1'b1;

    // Reset state of A
    @(negedge clk);
    chk("a_rst_p_tick", {31'd0, bus_a.p_tick}, 32'd0);
    chk("a_rst_x", {22'd0, bus_a.pixel_x}, 32'd0);
    chk("a_rst_y", {22'd0, bus_a.pixel_y}, 32'd0);
    chk("a_rst_video_on", {31'd0, bus_a.video_on}, 32'd1);
    chk("a_rst_vblank", {31'd0, bus_a.vblank}, 32'd0);
    chk("a_rst_hsync", {31'd0, bus_a.hsync}, 32'd1);
    chk("a_rst_vsync", {31'd0, bus_a.vsync}, 32'd1);
    chk("a_rst_line_start", {31'd0, bus_a.line_start}, 32'd0);

    // Release: tick in cycle 2, x=1 in cycle 3
    rst_a_n = 1'b1;
    #1;
    chk("a_c1_p_tick", {31'd0, bus_a.p_tick}, 32'd0);
    @(negedge clk);
    chk("a_c2_p_tick", {31'd0, bus_a.p_tick}, 32'd1);
    chk("a_c2_line_start", {31'd0, bus_a.line_start}, 32'd1);
    chk("a_c2_frame_start", {31'd0, bus_a.frame_start}, 32'd1);
    chk("a_c2_x", {22'd0, bus_a.pixel_x}, 32'd0);
    @(negedge clk);
    chk("a_c3_x", {22'd0, bus_a.pixel_x}, 32'd1);
    chk("a_c3_p_tick", {31'd0, bus_a.p_tick}, 32'd0);

    // Line and frame periods measured from the first frame_start
    n = 1;
    hs_low = 0;
    while (bus_a.line_start !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
      if (bus_a.hsync === 1'b0) hs_low++;
    end
    chk("line_period", n, 1600);
    chk("hsync_low_clks", hs_low, 192);
    while (bus_a.frame_start !== 1'b1 && n < 12000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_period", n, 11200);

    // Table-driven decode checks across one frame
    for (int i = 0; i < 13; i++) begin
      wait_pos(tbl[i].x, tbl[i].y, 12000);
      chk($sformatf("video_on_%0d", i), {31'd0, bus_a.video_on}, {31'd0, tbl[i].von});
      chk($sformatf("hsync_%0d", i), {31'd0, bus_a.hsync}, {31'd0, tbl[i].hs});
      chk($sformatf("vsync_%0d", i), {31'd0, bus_a.vsync}, {31'd0, tbl[i].vs});
      chk($sformatf("vblank_%0d", i), {31'd0, bus_a.vblank}, {31'd0, tbl[i].vb});
    end

    // en freeze for 37 clks on the tick cycle of x=300
    wait_pos(300, 1, 12000);
    chk("frz_pre_tick0", {31'd0, bus_a.p_tick}, 32'd0);
    @(negedge clk);
    chk("frz_pre_tick1", {31'd0, bus_a.p_tick}, 32'd1);
    bus_a.en = 1'b0;
    #1;
    chk("frz_tick_drop", {31'd0, bus_a.p_tick}, 32'd0);
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      chk("frz_x", {22'd0, bus_a.pixel_x}, 32'd300);
      chk("frz_y", {22'd0, bus_a.pixel_y}, 32'd1);
      chk("frz_p_tick", {31'd0, bus_a.p_tick}, 32'd0);
      chk("frz_hsync", {31'd0, bus_a.hsync}, 32'd1);
      chk("frz_video_on", {31'd0, bus_a.video_on}, 32'd1);
    end
    bus_a.en = 1'b1;
    #1;
    chk("resume_tick", {31'd0, bus_a.p_tick}, 32'd1);
    chk("resume_x", {22'd0, bus_a.pixel_x}, 32'd300);
    @(negedge clk);
    chk("resume_next_x", {22'd0, bus_a.pixel_x}, 32'd301);

    // Asynchronous reset mid-frame in the sync region
    wait_pos(700, 5, 12000);
    chk("pre_rst_hsync", {31'd0, bus_a.hsync}, 32'd0);
    chk("pre_rst_vsync", {31'd0, bus_a.vsync}, 32'd0);
    #2;
    rst_a_n = 1'b0;
    #1;
    chk("arst_x", {22'd0, bus_a.pixel_x}, 32'd0);
    chk("arst_y", {22'd0, bus_a.pixel_y}, 32'd0);
    chk("arst_video_on", {31'd0, bus_a.video_on}, 32'd1);
    chk("arst_vblank", {31'd0, bus_a.vblank}, 32'd0);
    chk("arst_hsync", {31'd0, bus_a.hsync}, 32'd1);
    chk("arst_vsync", {31'd0, bus_a.vsync}, 32'd1);
    chk("arst_p_tick", {31'd0, bus_a.p_tick}, 32'd0);
    @(negedge clk);
    rst_a_n = 1'b1;
    #1;
    chk("rerun_c1_tick", {31'd0, bus_a.p_tick}, 32'd0);
    @(negedge clk);
    chk("rerun_frame_start", {31'd0, bus_a.frame_start}, 32'd1);
    @(negedge clk);
    chk("rerun_x", {22'd0, bus_a.pixel_x}, 32'd1);

    // DUT B: CLK_DIV=1, positive syncs
    chk("b_rst_p_tick", {31'd0, bus_b.p_tick}, 32'd1);
    chk("b_rst_frame_start", {31'd0, bus_b.frame_start}, 32'd1);
    chk("b_rst_hsync", {31'd0, bus_b.hsync}, 32'd0);
    chk("b_rst_vsync", {31'd0, bus_b.vsync}, 32'd0);
    rst_b_n = 1'b1;
    #1;
    tick_low = 0;
    hs_hi = 0;
    run = 0;
    max_run = 0;
    for (int i = 0; i < 24; i++) begin
      if (i > 0) @(negedge clk);
      if (bus_b.p_tick !== 1'b1) tick_low++;
      if (bus_b.hsync === 1'b1) begin
        hs_hi++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (i == 12) begin
        chk("b_line2_line_start", {31'd0, bus_b.line_start}, 32'd1);
        chk("b_line2_frame_start", {31'd0, bus_b.frame_start}, 32'd0);
        chk("b_line2_y", {22'd0, bus_b.pixel_y}, 32'd1);
      end
    end
    chk("b_tick_low_clks", tick_low, 0);
    chk("b_hsync_high_clks", hs_hi, 4);
    chk("b_hsync_run", max_run, 2);

`ifdef VGA_TIMING_FRAME_CNT_EN
    // 23 edges seen so far; third frame wrap lands on edge 252
    repeat (251 - 23) @(negedge clk);
    chk("fc_before", {16'd0, bus_b.frame_cnt}, 32'd2);
    chk("fc_before_x", {22'd0, bus_b.pixel_x}, 32'd11);
    chk("fc_before_y", {22'd0, bus_b.pixel_y}, 32'd6);
    @(negedge clk);
    chk("fc_after", {16'd0, bus_b.frame_cnt}, 32'd3);
    chk("fc_after_frame_start", {31'd0, bus_b.frame_start}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
